tlb_array: RTL and testbench

- Fully-associative joint TLB; the responder side of the CP0 TLB interface.
- Serves CP0 TLBR, TLBWI/TLBWR and TLBP.
- Serves two registered address-translation ports: fetch (port I) and load/store (port D), each with 1-cycle latency.
- Sits beside CP0; the I and D result regs feed the IF and MEM exception/cache-select logic.

---
 rtl/tlb_array.sv | 183 ++++++++++++++++++
 tb/tb_tlb_array.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_array.sv
// Fully-associative joint TLB: CP0 read/write/probe responder plus two
// registered 1-cycle translation ports (I = fetch, D = load/store).
package tlb_pkg;
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;
endpackage

module tlb_array
    import tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       tlb_asid,
    input  logic             kseg0_uncached,
    input  logic [IDX_W-1:0] tlbrw_index,
    input  logic             tlbrw_we,
    input  tlb_entry_t       tlbrw_wdata,
    output tlb_entry_t       tlbrw_rdata,
    input  logic [31:0]      tlbp_entry_hi,
    output logic [31:0]      tlbp_index,
    input  logic             i_req,
    input  logic [31:0]      i_vaddr,
    output logic             i_resp_valid,
    output logic [31:0]      i_paddr,
    output logic             i_refill,
    output logic             i_invalid,
    output logic             i_uncached,
    input  logic             d_req,
    input  logic [31:0]      d_vaddr,
    input  logic             d_store,
    output logic             d_resp_valid,
    output logic [31:0]      d_paddr,
    output logic             d_refill,
    output logic             d_invalid,
    output logic             d_modify,
    output logic             d_uncached
);

    typedef struct packed {
        logic [31:0] paddr;
        logic        refill;
        logic        invalid;
        logic        modify;
        logic        uncached;
    } xlate_t;

    tlb_entry_t entry_q [TLB_ENTRIES];

    logic [TLB_ENTRIES-1:0] i_match, d_match, p_match;
    logic [IDX_W:0]         i_sel, d_sel, p_sel;
    xlate_t                 i_res_d, i_res_q, d_res_d, d_res_q;
    logic                   i_valid_q, d_valid_q;
    logic                   unused_hi_bits;

    function automatic logic entry_hit(input tlb_entry_t e, input logic [18:0] vpn2,
                                       input logic [7:0] asid);
        return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
    endfunction

    // {hit, index}; scanning downward leaves the lowest matching index.
    function automatic logic [IDX_W:0] first_hit(input logic [TLB_ENTRIES-1:0] m);
        logic [IDX_W:0] r;
        r = '0;
        for (int k = TLB_ENTRIES - 1; k >= 0; k--) begin
            if (m[k]) r = {1'b1, IDX_W'(k)};
        end
        return r;
    endfunction

    function automatic xlate_t translate(input logic [31:0] vaddr, input logic store,
                                         input logic k0_unc, input logic hit,
                                         input tlb_entry_t e);
        xlate_t      r;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        v;
        logic        d;
        r   = '0;
        pfn = vaddr[12] ? e.pfn1 : e.pfn0;
        c   = vaddr[12] ? e.c1   : e.c0;
        v   = vaddr[12] ? e.v1   : e.v0;
        d   = vaddr[12] ? e.d1   : e.d0;
        case (vaddr[31:29])
            3'b100: begin
                r.paddr    = {3'b000, vaddr[28:0]};
                r.uncached = k0_unc;
            end
            3'b101: begin
                r.paddr    = {3'b000, vaddr[28:0]};
                r.uncached = 1'b1;
            end
            default: begin
                if (!hit) begin
                    r.refill = 1'b1;
                end else begin
                    r.paddr    = {pfn, vaddr[11:0]};
                    r.uncached = (c != 3'd3);
                    if (!v)               r.invalid = 1'b1;
                    else if (store && !d) r.modify  = 1'b1;
                end
            end
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TLB_ENTRIES; k++) entry_q[k] <= '0;
        end else if (tlbrw_we) begin
            entry_q[tlbrw_index] <= tlbrw_wdata;
        end
    end

    assign tlbrw_rdata = entry_q[tlbrw_index];

    always_comb begin
        i_match = '0;
        d_match = '0;
        p_match = '0;
        for (int k = 0; k < TLB_ENTRIES; k++) begin
            i_match[k] = entry_hit(entry_q[k], i_vaddr[31:13], tlb_asid);
            d_match[k] = entry_hit(entry_q[k], d_vaddr[31:13], tlb_asid);
            p_match[k] = entry_hit(entry_q[k], tlbp_entry_hi[31:13], tlbp_entry_hi[7:0]);
        end
    end

    assign i_sel = first_hit(i_match);
    assign d_sel = first_hit(d_match);
    assign p_sel = first_hit(p_match);

    assign tlbp_index     = p_sel[IDX_W] ? 32'(p_sel[IDX_W-1:0]) : 32'h8000_0000;
    assign unused_hi_bits = ^tlbp_entry_hi[12:8];

    always_comb begin
        i_res_d = translate(i_vaddr, 1'b0, kseg0_uncached, i_sel[IDX_W],
                            entry_q[i_sel[IDX_W-1:0]]);
        d_res_d = translate(d_vaddr, d_store, kseg0_uncached, d_sel[IDX_W],
                            entry_q[d_sel[IDX_W-1:0]]);
    end

    // Result regs hold between requests; reset drops any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            i_res_q   <= '0;
            d_res_q   <= '0;
        end else begin
            i_valid_q <= i_req;
            d_valid_q <= d_req;
            if (i_req) i_res_q <= i_res_d;
            if (d_req) d_res_q <= d_res_d;
        end
    end

    assign i_resp_valid = i_valid_q;
    assign i_paddr      = i_res_q.paddr;
    assign i_refill     = i_res_q.refill;
    assign i_invalid    = i_res_q.invalid;
    assign i_uncached   = i_res_q.uncached;

    assign d_resp_valid = d_valid_q;
    assign d_paddr      = d_res_q.paddr;
    assign d_refill     = d_res_q.refill;
    assign d_invalid    = d_res_q.invalid;
    assign d_modify     = d_res_q.modify;
    assign d_uncached   = d_res_q.uncached;

endmodule

// File: tb/tb_tlb_array.sv
// Scoreboard bench for tlb_array: stimulus pushes expected lookup results,
// a negedge monitor pops and compares whenever a port presents a response.
module tb_tlb_array;
    import tlb_pkg::*;

    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       tlb_asid;
    logic             kseg0_uncached;
    logic [IDX_W-1:0] tlbrw_index;
    logic             tlbrw_we;
    tlb_entry_t       tlbrw_wdata;
    tlb_entry_t       tlbrw_rdata;
    logic [31:0]      tlbp_entry_hi;
    logic [31:0]      tlbp_index;
    logic             i_req, i_resp_valid, i_refill, i_invalid, i_uncached;
    logic [31:0]      i_vaddr, i_paddr;
    logic             d_req, d_store, d_resp_valid, d_refill, d_invalid, d_modify, d_uncached;
    logic [31:0]      d_vaddr, d_paddr;

    always #5 clk = ~clk;

    tlb_array #(.TLB_ENTRIES(16)) dut (
        .clk(clk), .reset(reset), .tlb_asid(tlb_asid), .kseg0_uncached(kseg0_uncached),
        .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we), .tlbrw_wdata(tlbrw_wdata),
        .tlbrw_rdata(tlbrw_rdata), .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index),
        .i_req(i_req), .i_vaddr(i_vaddr), .i_resp_valid(i_resp_valid), .i_paddr(i_paddr),
        .i_refill(i_refill), .i_invalid(i_invalid), .i_uncached(i_uncached),
        .d_req(d_req), .d_vaddr(d_vaddr), .d_store(d_store), .d_resp_valid(d_resp_valid),
        .d_paddr(d_paddr), .d_refill(d_refill), .d_invalid(d_invalid),
        .d_modify(d_modify), .d_uncached(d_uncached)
    );

    typedef struct {
        string       name;
        logic [35:0] v;   // {paddr, refill, invalid, modify, uncached}
    } resp_t;

    resp_t d_exp_q[$];
    resp_t i_exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_d(input string name, input logic [31:0] pa, input logic rf,
                          input logic iv, input logic md, input logic uc);
        resp_t e;
        e.name = name;
        e.v    = {pa, rf, iv, md, uc};
        d_exp_q.push_back(e);
    endtask

    task automatic push_i(input string name, input logic [31:0] pa, input logic rf,
                          input logic iv, input logic uc);
        resp_t e;
        e.name = name;
        e.v    = {pa, rf, iv, 1'b0, uc};
        i_exp_q.push_back(e);
    endtask

    task automatic d_look(input string name, input logic [31:0] va, input logic st,
                          input logic [31:0] pa, input logic rf, input logic iv,
                          input logic md, input logic uc);
        d_req   = 1'b1;
        d_vaddr = va;
        d_store = st;
        push_d(name, pa, rf, iv, md, uc);
        tick();
        d_req   = 1'b0;
        d_store = 1'b0;
    endtask

    task automatic i_look(input string name, input logic [31:0] va, input logic [31:0] pa,
                          input logic rf, input logic iv, input logic uc);
        i_req   = 1'b1;
        i_vaddr = va;
        push_i(name, pa, rf, iv, uc);
        tick();
        i_req = 1'b0;
    endtask

    task automatic tlb_write(input logic [IDX_W-1:0] idx, input tlb_entry_t e);
        tlbrw_we    = 1'b1;
        tlbrw_index = idx;
        tlbrw_wdata = e;
        tick();
        tlbrw_we = 1'b0;
    endtask

    task automatic probe(input string name, input logic [31:0] key, input logic [31:0] exp);
        tlbp_entry_hi = key;
        #1;
        check(name, tlbp_index, exp);
    endtask

    function automatic tlb_entry_t mk(input logic [18:0] vpn2, input logic [7:0] asid,
                                      input logic g, input logic [19:0] pfn0,
                                      input logic [2:0] c0, input logic d0, input logic v0,
                                      input logic [19:0] pfn1, input logic [2:0] c1,
                                      input logic d1, input logic v1);
        tlb_entry_t e;
        e.vpn2 = vpn2; e.asid = asid; e.g = g;
        e.pfn0 = pfn0; e.c0 = c0; e.d0 = d0; e.v0 = v0;
        e.pfn1 = pfn1; e.c1 = c1; e.d1 = d1; e.v1 = v1;
        return e;
    endfunction

    always @(negedge clk) begin
        resp_t e;
        if (d_resp_valid === 1'b1) begin
            if (d_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL d_unexpected_resp: got paddr %h, expected no response", d_paddr);
            end else begin
                e = d_exp_q.pop_front();
                check(e.name, {d_paddr, d_refill, d_invalid, d_modify, d_uncached}, e.v);
            end
        end
        if (i_resp_valid === 1'b1) begin
            if (i_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL i_unexpected_resp: got paddr %h, expected no response", i_paddr);
            end else begin
                e = i_exp_q.pop_front();
                check(e.name, {i_paddr, i_refill, i_invalid, 1'b0, i_uncached}, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tlb_entry_t e5, e3, e9, e2;

        reset = 1'b1; tlb_asid = '0; kseg0_uncached = 1'b0;
        tlbrw_index = '0; tlbrw_we = 1'b0; tlbrw_wdata = '0; tlbp_entry_hi = '0;
        i_req = 1'b0; i_vaddr = '0; d_req = 1'b0; d_vaddr = '0; d_store = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_d_valid", d_resp_valid, 1'b0);
        check("rst_i_valid", i_resp_valid, 1'b0);
        check("rst_d_paddr", d_paddr, 32'h0);
        tlbrw_index = 4'd15;
        #1;
        check("rst_entry15", tlbrw_rdata, '0);
        probe("probe_after_reset", 32'h0080_0012, 32'h8000_0000);
        d_look("d_refill_after_reset", 32'h0080_0ABC, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        e5 = mk(19'h400, 8'h12, 1'b0, 20'h12345, 3'd3, 1'b0, 1'b1,
                20'h0ABCD, 3'd2, 1'b1, 1'b1);
        tlb_write(4'd5, e5);
        tlb_asid = 8'h12;
        d_look("d_even_load", 32'h0080_0ABC, 1'b0, 32'h1234_5ABC, 1'b0, 1'b0, 1'b0, 1'b0);
        d_look("d_odd_load", 32'h0080_1ABC, 1'b0, 32'h0ABC_DABC, 1'b0, 1'b0, 1'b0, 1'b1);
        d_look("d_even_store_modify", 32'h0080_0ABC, 1'b1, 32'h1234_5ABC, 1'b0, 1'b0, 1'b1, 1'b0);
        d_look("d_odd_store_dirty", 32'h0080_1ABC, 1'b1, 32'h0ABC_DABC, 1'b0, 1'b0, 1'b0, 1'b1);
        probe("probe_hit5", 32'h0080_0012, 32'd5);
        tlbrw_index = 4'd5;
        #1;
        check("tlbr_idx5", tlbrw_rdata, e5);

        tlb_asid = 8'h34;
        d_look("d_asid_mismatch", 32'h0080_0ABC, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        e5.g = 1'b1;
        tlb_write(4'd5, e5);
        d_look("d_global_hit", 32'h0080_0ABC, 1'b0, 32'h1234_5ABC, 1'b0, 1'b0, 1'b0, 1'b0);
        e5.v0 = 1'b0;
        tlb_write(4'd5, e5);
        d_look("d_invalid", 32'h0080_0ABC, 1'b0, 32'h1234_5ABC, 1'b0, 1'b1, 1'b0, 1'b0);
        d_look("d_invalid_over_modify", 32'h0080_0ABC, 1'b1, 32'h1234_5ABC, 1'b0, 1'b1, 1'b0, 1'b0);

        i_look("i_kseg1", 32'hBFC0_0000, 32'h1FC0_0000, 1'b0, 1'b0, 1'b1);
        kseg0_uncached = 1'b0;
        i_look("i_kseg0_cached", 32'h8000_1000, 32'h0000_1000, 1'b0, 1'b0, 1'b0);
        kseg0_uncached = 1'b1;
        i_look("i_kseg0_uncached", 32'h8000_1000, 32'h0000_1000, 1'b0, 1'b0, 1'b1);
        kseg0_uncached = 1'b0;
        d_look("d_kseg0_store_nofault", 32'h8012_3456, 1'b1, 32'h0012_3456, 1'b0, 1'b0, 1'b0, 1'b0);
        i_look("i_mapped_odd", 32'h0080_1ABC, 32'h0ABC_DABC, 1'b0, 1'b0, 1'b1);

        e3 = mk(19'h400, 8'h00, 1'b1, 20'h33333, 3'd3, 1'b1, 1'b1, 20'h0, 3'd3, 1'b0, 1'b0);
        e9 = mk(19'h400, 8'h00, 1'b1, 20'h99999, 3'd3, 1'b1, 1'b1, 20'h0, 3'd3, 1'b0, 1'b0);
        tlb_write(4'd9, e9);
        tlb_write(4'd3, e3);
        probe("probe_dup_lowest", 32'h0080_0012, 32'd3);
        i_req = 1'b1; i_vaddr = 32'h0080_0000;
        d_req = 1'b1; d_vaddr = 32'h0080_0000; d_store = 1'b0;
        push_i("i_dup_lowest", 32'h3333_3000, 1'b0, 1'b0, 1'b0);
        push_d("d_dup_lowest", 32'h3333_3000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        i_req = 1'b0; d_req = 1'b0;

        e2 = mk(19'h1000, 8'h12, 1'b0, 20'h55555, 3'd3, 1'b1, 1'b1, 20'h0, 3'd3, 1'b0, 1'b0);
        tlb_asid      = 8'h12;
        tlbrw_we      = 1'b1;
        tlbrw_index   = 4'd2;
        tlbrw_wdata   = e2;
        d_req         = 1'b1;
        d_vaddr       = 32'h0200_0123;
        push_d("d_same_cycle_write_miss", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        probe("probe_same_cycle_write_miss", 32'h0200_0012, 32'h8000_0000);
        check("tlbr_old_during_write", tlbrw_rdata, '0);
        tick();
        tlbrw_we = 1'b0;
        push_d("d_next_cycle_hit", 32'h5555_5123, 1'b0, 1'b0, 1'b0, 1'b0);
        probe("probe_next_cycle_hit", 32'h0200_0012, 32'd2);
        tick();
        d_req = 1'b0;

        i_req = 1'b1; i_vaddr = 32'h0080_0000;
        d_req = 1'b1; d_vaddr = 32'h0080_1ABC;
        push_i("i_before_midreset", 32'h3333_3000, 1'b0, 1'b0, 1'b0);
        push_d("d_before_midreset", 32'h0000_0ABC, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        i_req = 1'b0; d_req = 1'b0;
        reset = 1'b1;
        tick();
        check("midrst_d_valid", d_resp_valid, 1'b0);
        check("midrst_i_valid", i_resp_valid, 1'b0);
        check("midrst_d_flags", {d_paddr, d_refill, d_invalid, d_modify, d_uncached}, 36'h0);
        check("midrst_i_flags", {i_paddr, i_refill, i_invalid, i_uncached}, 35'h0);
        probe("probe_after_midreset", 32'h0080_0012, 32'h8000_0000);
        reset = 1'b0;

        repeat (3) tick();
        check("d_queue_drained", d_exp_q.size(), 0);
        check("i_queue_drained", i_exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
